// File: rtl/mips16_pkg.sv
// Shared types and constants for the 16-bit MIPS pipeline.
package mips16_pkg;

  localparam int REG_AW = 3;
  localparam int DATA_W = 16;

  // Conditional branch encodings carried with each instruction.
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10,
    BR_LT   = 2'b11
  } br_type_t;

  // One instruction's worth of state handed to the memory stage.
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] dest;
    logic              mem_rd;
    logic              mem_wr;
    logic              reg_wr;
  } exmem_entry_t;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_TWO   = 2'b10
  } buf_state_t;

  // Branch condition evaluated from the ALU flags.
  function automatic logic branch_taken(input br_type_t bt, input logic zero, input logic less);
    logic taken;
    taken = 1'b0;
    case (bt)
      BR_EQ:   taken = zero;
      BR_NE:   taken = ~zero;
      BR_LT:   taken = less;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer. Outputs come from the main
// entry; the skid entry catches a push that arrives while main is stalled.
// in_ready depends only on registered state.
module skid_buf2
  import mips16_pkg::*;
#(
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   push,
  input  entry_t in_data,
  output logic   in_ready,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data
);

  buf_state_t state_reg;
  buf_state_t state_next;
  entry_t     main_reg;
  entry_t     skid_reg;
  logic       load_main;
  logic       main_from_skid;
  logic       load_skid;
  logic       pop;

  assign out_valid = (state_reg != BUF_EMPTY);
  assign in_ready  = (state_reg != BUF_TWO);
  assign pop       = out_valid & out_ready;
  assign out_data  = main_reg;

  // Next-state and register load decisions; flush overrides everything.
  always_comb begin
    state_next     = state_reg;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      BUF_EMPTY: begin
        if (push) begin
          load_main  = 1'b1;
          state_next = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          load_skid  = 1'b1;
          state_next = BUF_TWO;
        end else if (pop) begin
          state_next = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_next     = BUF_ONE;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
    if (flush) begin
      state_next     = BUF_EMPTY;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // State and entry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= BUF_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load_main) main_reg <= main_from_skid ? skid_reg : in_data;
      if (load_skid) skid_reg <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory stage: resolves branches, pulses a one-cycle PC
// redirect for taken branches, counts them, and forwards non-branch
// instructions to the memory stage through a 2-entry skid buffer.
module ex_mem_stage
  import mips16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_less,
  input  logic [DATA_W-1:0] pc_plus1,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [REG_AW-1:0] dest,
  input  logic [1:0]        br_type,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              reg_wr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic              out_reg_wr,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  br_taken_cnt
);

  logic         accept;
  logic         is_branch;
  logic         taken;
  logic         push;
  exmem_entry_t in_entry;
  exmem_entry_t out_entry;

  // The instruction offered while a redirect is pulsing is wrong-path:
  // it is consumed (in_ready stays high) but never acted on.
  assign accept    = in_valid & in_ready & ~flush & ~redirect_valid;
  assign is_branch = (br_type != BR_NONE);
  assign taken     = branch_taken(br_type_t'(br_type), alu_zero, alu_less);
  assign push      = accept & ~is_branch;

  assign in_entry = '{result:     alu_out,
                      store_data: rt_data,
                      dest:       dest,
                      mem_rd:     mem_rd,
                      mem_wr:     mem_wr,
                      reg_wr:     reg_wr};

  skid_buf2 #(
    .entry_t (exmem_entry_t)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .in_data   (in_entry),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  assign out_result     = out_entry.result;
  assign out_store_data = out_entry.store_data;
  assign out_dest       = out_entry.dest;
  assign out_mem_rd     = out_entry.mem_rd;
  assign out_mem_wr     = out_entry.mem_wr;
  assign out_reg_wr     = out_entry.reg_wr;

  // Redirect pulse, target capture and saturating taken-branch counter.
  // flush is already folded into accept, so it suppresses all three.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      br_taken_cnt   <= '0;
    end else begin
      redirect_valid <= accept & is_branch & taken;
      if (accept && is_branch && taken) begin
        redirect_pc <= pc_plus1 + imm;
        if (br_taken_cnt != {CNT_W{1'b1}}) br_taken_cnt <= br_taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage (counter width 4).
module tb_ex_mem_stage;
  import mips16_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] alu_out = '0;
  logic        alu_zero = 1'b0;
  logic        alu_less = 1'b0;
  logic [15:0] pc_plus1 = '0;
  logic [15:0] imm = '0;
  logic [15:0] rt_data = '0;
  logic [2:0]  dest = '0;
  logic [1:0]  br_type = 2'b00;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic        reg_wr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [15:0] out_store_data;
  logic [2:0]  out_dest;
  logic        out_mem_rd;
  logic        out_mem_wr;
  logic        out_reg_wr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [3:0]  br_taken_cnt;

  int checks = 0;
  int failures = 0;

  ex_mem_stage #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_less(alu_less),
    .pc_plus1(pc_plus1), .imm(imm), .rt_data(rt_data), .dest(dest),
    .br_type(br_type), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_dest(out_dest),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_reg_wr(out_reg_wr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_taken_cnt(br_taken_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle before inputs change or outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    br_type  = 2'b00;
    alu_out  = '0;
    rt_data  = '0;
    dest     = '0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    reg_wr   = 1'b0;
    alu_zero = 1'b0;
    alu_less = 1'b0;
  endtask

  task automatic offer_alu(input logic [15:0] res, input logic [15:0] sd, input logic [2:0] d,
                           input logic rd, input logic wr, input logic rw);
    in_valid = 1'b1;
    br_type  = 2'b00;
    alu_out  = res;
    rt_data  = sd;
    dest     = d;
    mem_rd   = rd;
    mem_wr   = wr;
    reg_wr   = rw;
    $display("tx alu res=%h dest=%0d", res, d);
  endtask

  task automatic offer_br(input logic [1:0] bt, input logic z, input logic l,
                          input logic [15:0] pc, input logic [15:0] off);
    in_valid = 1'b1;
    br_type  = bt;
    alu_zero = z;
    alu_less = l;
    pc_plus1 = pc;
    imm      = off;
    alu_out  = '0;
    reg_wr   = 1'b0;
    $display("tx br type=%0d zero=%0d less=%0d pc=%h imm=%h", bt, z, l, pc, off);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 16'h0000) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0000", redirect_pc); end
    checks++; if (br_taken_cnt !== 4'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", br_taken_cnt); end
    checks++; if (out_result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", out_result); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_alu();
    out_ready = 1'b1;
    offer_alu(16'h1234, 16'h5555, 3'd3, 1'b0, 1'b0, 1'b1);
    step();
    idle_in();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL alu_valid got=%b exp=1", out_valid); end
    checks++; if (out_result !== 16'h1234) begin failures++; $display("FAIL alu_result got=%h exp=1234", out_result); end
    checks++; if (out_dest !== 3'd3) begin failures++; $display("FAIL alu_dest got=%0d exp=3", out_dest); end
    checks++; if (out_reg_wr !== 1'b1) begin failures++; $display("FAIL alu_reg_wr got=%b exp=1", out_reg_wr); end
    checks++; if (out_store_data !== 16'h5555) begin failures++; $display("FAIL alu_store got=%h exp=5555", out_store_data); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL alu_no_redirect got=%b exp=0", redirect_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL alu_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_branch_taken();
    offer_br(2'b01, 1'b1, 1'b0, 16'h0010, 16'hFFFC);
    step();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL beq_redirect got=%b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 16'h000C) begin failures++; $display("FAIL beq_target got=%h exp=000c", redirect_pc); end
    checks++; if (br_taken_cnt !== 4'h1) begin failures++; $display("FAIL beq_cnt got=%h exp=1", br_taken_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL beq_no_out got=%b exp=0", out_valid); end
    // Wrong-path instruction offered during the pulse.
    offer_alu(16'h7777, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL discard_in_ready got=%b exp=1", in_ready); end
    step();
    idle_in();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL beq_pulse_len got=%b exp=0", redirect_valid); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL discard_dropped got=%b exp=0", out_valid); end
  endtask

  task automatic test_not_taken();
    offer_br(2'b11, 1'b0, 1'b0, 16'h0040, 16'h0008);
    step();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL blt_nt_redirect got=%b exp=0", redirect_valid); end
    offer_br(2'b10, 1'b1, 1'b1, 16'h0050, 16'h0008);
    step();
    idle_in();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL bne_nt_redirect got=%b exp=0", redirect_valid); end
    checks++; if (br_taken_cnt !== 4'h1) begin failures++; $display("FAIL nt_cnt got=%h exp=1", br_taken_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL nt_no_out got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    offer_br(2'b10, 1'b0, 1'b0, 16'h0100, 16'h0005);
    step();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 16'h0105) begin failures++; $display("FAIL b2b_first_pc got=%h exp=0105", redirect_pc); end
    checks++; if (br_taken_cnt !== 4'h2) begin failures++; $display("FAIL b2b_cnt1 got=%h exp=2", br_taken_cnt); end
    offer_br(2'b11, 1'b0, 1'b1, 16'h0200, 16'h0001);
    step();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL b2b_second_dropped got=%b exp=0", redirect_valid); end
    checks++; if (br_taken_cnt !== 4'h2) begin failures++; $display("FAIL b2b_cnt2 got=%h exp=2", br_taken_cnt); end
    // Same branch offered again outside the discard slot is taken.
    step();
    idle_in();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL b2b_retry got=%b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 16'h0201) begin failures++; $display("FAIL b2b_retry_pc got=%h exp=0201", redirect_pc); end
    checks++; if (br_taken_cnt !== 4'h3) begin failures++; $display("FAIL b2b_cnt3 got=%h exp=3", br_taken_cnt); end
    step();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    offer_alu(16'hAAAA, 16'h0001, 3'd1, 1'b1, 1'b0, 1'b1);
    step();
    checks++; if (out_result !== 16'hAAAA) begin failures++; $display("FAIL stall_first got=%h exp=aaaa", out_result); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready1 got=%b exp=1", in_ready); end
    offer_alu(16'hBBBB, 16'h0002, 3'd2, 1'b0, 1'b1, 1'b0);
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_full got=%b exp=0", in_ready); end
    checks++; if (out_result !== 16'hAAAA) begin failures++; $display("FAIL stall_hold got=%h exp=aaaa", out_result); end
    checks++; if (out_mem_rd !== 1'b1) begin failures++; $display("FAIL stall_mem_rd got=%b exp=1", out_mem_rd); end
    // Offered while full: not accepted, must never appear.
    offer_alu(16'hCCCC, 16'h0003, 3'd4, 1'b0, 1'b0, 1'b1);
    step();
    idle_in();
    checks++; if (out_result !== 16'hAAAA || out_valid !== 1'b1) begin failures++; $display("FAIL stall_stable got=%h/%b exp=aaaa/1", out_result, out_valid); end
    out_ready = 1'b1;
    step();
    checks++; if (out_result !== 16'hBBBB || out_valid !== 1'b1) begin failures++; $display("FAIL release_second got=%h/%b exp=bbbb/1", out_result, out_valid); end
    checks++; if (out_mem_wr !== 1'b1) begin failures++; $display("FAIL release_mem_wr got=%b exp=1", out_mem_wr); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_throughput();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      offer_alu(16'(i * 16'h0101), 16'h0000, 3'(i), 1'b0, 1'b0, 1'b1);
      step();
      checks++; if (out_valid !== 1'b1 || out_result !== 16'(i * 16'h0101)) begin
        failures++; $display("FAIL thru_%0d got=%h/%b exp=%h/1", i, out_result, out_valid, 16'(i * 16'h0101));
      end
    end
    idle_in();
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL thru_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer_alu(16'h1111, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1);
    step();
    offer_alu(16'h2222, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b1);
    step();
    idle_in();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_two_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_two_ready got=%b exp=1", in_ready); end
    // One entry buffered plus a taken branch offered in the flush cycle.
    offer_alu(16'h3333, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1);
    step();
    offer_br(2'b01, 1'b1, 1'b0, 16'h0300, 16'h0010);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_in();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL flush_redirect got=%b exp=0", redirect_valid); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_one_valid got=%b exp=0", out_valid); end
    checks++; if (br_taken_cnt !== 4'h3) begin failures++; $display("FAIL flush_cnt got=%h exp=3", br_taken_cnt); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_saturate_and_reset();
    for (int i = 0; i < 14; i++) begin
      offer_br(2'b01, 1'b1, 1'b0, 16'h0400, 16'h0002);
      step();
      idle_in();
      step();
      if (i == 10) begin
        checks++; if (br_taken_cnt !== 4'hE) begin failures++; $display("FAIL cnt_pre_sat got=%h exp=e", br_taken_cnt); end
      end
    end
    checks++; if (br_taken_cnt !== 4'hF) begin failures++; $display("FAIL cnt_saturated got=%h exp=f", br_taken_cnt); end
    // Mid-stream: buffered entry and a live redirect, then async reset.
    out_ready = 1'b0;
    offer_alu(16'h4444, 16'h9999, 3'd7, 1'b1, 1'b1, 1'b1);
    step();
    offer_br(2'b01, 1'b1, 1'b0, 16'h0500, 16'h0003);
    step();
    idle_in();
    checks++; if (redirect_valid !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset got=%b/%b exp=1/1", redirect_valid, out_valid); end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b/%b exp=0/0", out_valid, redirect_valid); end
    checks++; if (br_taken_cnt !== 4'h0 || redirect_pc !== 16'h0000) begin failures++; $display("FAIL async_reset_cnt_pc got=%h/%h exp=0/0000", br_taken_cnt, redirect_pc); end
    checks++; if (out_result !== 16'h0000 || out_store_data !== 16'h0000 || out_dest !== 3'd0) begin failures++; $display("FAIL async_reset_data got=%h/%h/%0d exp=0", out_result, out_store_data, out_dest); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready got=%b exp=1", in_ready); end
    step();
    reset = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    idle_in();
    test_reset();
    test_alu();
    test_branch_taken();
    test_not_taken();
    test_back_to_back();
    test_stall();
    test_throughput();
    test_flush();
    test_saturate_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage of the 16-bit MIPS core, directly downstream of the ALU. Each cycle it captures the ALU result and flags with the instruction's control bits, resolves conditional branches from the ALU `zero`/`less` flags, and issues a one-cycle PC redirect. Non-branch instructions go to the memory stage through a 2-entry skid buffer with a valid/ready handshake, so a memory-stage stall never drops an ALU result.

## Interface
- `CNT_W`, default 16: width of the saturating branch-taken counter.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `flush` in 1: synchronous kill of buffered instructions and any pending redirect.
- `in_valid` in 1: upstream has an instruction.
- `in_ready` out 1: stage can accept this cycle.
- `alu_out` in 16: ALU result.
- `alu_zero`, `alu_less` in 1 each: ALU flags.
- `pc_plus1` in 16: PC of instruction + 1.
- `imm` in 16: sign-extended branch offset.
- `rt_data` in 16: store data.
- `dest` in 3: destination register.
- `br_type` in 2: 00 none, 01 BEQ, 10 BNE, 11 BLT.
- `mem_rd`, `mem_wr`, `reg_wr` in 1 each: memory/writeback controls.
- `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `out_result` out 16, `out_store_data` out 16, `out_dest` out 3, `out_mem_rd`/`out_mem_wr`/`out_reg_wr` out 1.
- `redirect_valid` out 1: one-cycle pulse, fetch must load `redirect_pc`.
- `redirect_pc` out 16: branch target.
- `br_taken_cnt` out CNT_W: saturating count of taken branches.

## Operation
- Accept = `in_valid & in_ready & ~flush & ~redirect_valid`. If `redirect_valid` is high, the instruction offered that cycle is wrong-path and is discarded: `in_ready` stays high, so it is consumed and dropped.
- Branch (`br_type != 00`): taken when BEQ & `alu_zero`, BNE & `~alu_zero`, BLT & `alu_less`. Target = `pc_plus1 + imm`, modulo 2^16. Branches never enter the buffer, taken or not.
- Taken branch: next cycle `redirect_valid`=1 and `redirect_pc`=target for exactly one cycle. `br_taken_cnt` increments and saturates at all-ones.
- Non-branch: the entry {alu_out, rt_data, dest, mem_rd, mem_wr, reg_wr} is pushed into the skid buffer.
- Buffer states:
  - EMPTY: accept → ONE.
  - ONE (main valid): accept with no pop → TWO. Pop with no accept → EMPTY. Both → ONE, with the new entry in main.
  - TWO: main + skid valid. Pop → ONE, skid moves to main. No accept is possible in TWO.
- Pop = `out_valid & out_ready`.
- `in_ready` = ~(state==TWO). It is registered-state-derived, with no combinational path from `out_ready`.
- `out_*` are driven from the main entry. They hold stable while `out_valid & ~out_ready`.
- `flush` has priority over accept, pop and redirect: next state EMPTY, `redirect_valid` 0 next cycle. The counter is not cleared.
- `reset` mid-operation: everything clears immediately. In-flight data and any pending redirect are lost.

## Timing
- Reset values: `out_valid` 0; all `out_*` data 0; `redirect_valid` 0; `redirect_pc` 0; `br_taken_cnt` 0. `in_ready` is 1 (state EMPTY).
- Latency: accept at edge N → `out_valid` high after edge N, i.e. 1 cycle when EMPTY.
- Redirect: taken branch accepted at edge N → `redirect_valid` high for the cycle following edge N.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- Simultaneous accept and pop in ONE: no bubble; `out_valid` stays 1.
- Two back-to-back taken branches cannot both redirect: the second arrives in the discard slot and is dropped.

## Structure
- Package `mips16_pkg`:
  - `br_type` encodings BR_NONE/BR_EQ/BR_NE/BR_LT.
  - `REG_AW`=3, `DATA_W`=16.
  - Packed `exmem_entry_t` {result, store_data, dest, mem_rd, mem_wr, reg_wr}.
- One sub-module `skid_buf2`: generic 2-entry valid/ready buffer parameterised on entry type/width. Branch resolution, redirect and counter stay in `ex_mem_stage`.

## Test plan
- ADD result 0x1234, dest=3, reg_wr=1, `out_ready`=1 → next cycle `out_valid`=1, `out_result`=0x1234, `out_dest`=3; no redirect.
- BEQ, `alu_zero`=1, `pc_plus1`=0x0010, `imm`=0xFFFC → `redirect_valid` pulse with `redirect_pc`=0x000C; `br_taken_cnt`=1; `out_valid` stays 0; instruction offered during the pulse is dropped.
- BLT with `alu_less`=0, then BNE with `alu_zero`=1 → no redirect, counter unchanged.
- `out_ready`=0, push 0xAAAA, 0xBBBB → `in_ready`=0 after the second. Release → 0xAAAA then 0xBBBB on consecutive cycles; `in_ready` back to 1.
- State TWO plus a taken branch pending, assert `flush` → next cycle `out_valid`=0, `redirect_valid`=0, `in_ready`=1.
- Preload `br_taken_cnt` near all-ones via taken branches (CNT_W=4: 16 branches) → holds at 0xF. Then async `reset` mid-stream → all outputs 0 immediately.
